// File: rtl/nz_read_scheduler_if.sv
// Bundle between the non-zero read scheduler and its surroundings: start and
// flag snapshot inputs, the register-file read port, the (index, value)
// output stream and status. The macro NZ_SCHED_RELU_SKIP_EN adds pos_flags.
interface nz_read_scheduler_if #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned REG_DEPTH = 64
);
    localparam int unsigned ADDR_W = $clog2(REG_DEPTH);
    localparam int unsigned CNT_W  = $clog2(REG_DEPTH + 1);

    logic                 start;
    logic [REG_DEPTH-1:0] nz_flags;
`ifdef NZ_SCHED_RELU_SKIP_EN
    logic [REG_DEPTH-1:0] pos_flags;
`endif
    logic                 rf_read_en;
    logic [ADDR_W-1:0]    rf_read_addr;
    logic [BIT_WIDTH-1:0] rf_read_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    out_idx;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     nz_count;

`ifdef NZ_SCHED_RELU_SKIP_EN
    modport master (
        output start, nz_flags, pos_flags, rf_read_data, out_ready,
        input  rf_read_en, rf_read_addr, out_valid, out_idx, out_data,
               out_last, busy, done, nz_count
    );
    modport slave (
        input  start, nz_flags, pos_flags, rf_read_data, out_ready,
        output rf_read_en, rf_read_addr, out_valid, out_idx, out_data,
               out_last, busy, done, nz_count
    );
`else
    modport master (
        output start, nz_flags, rf_read_data, out_ready,
        input  rf_read_en, rf_read_addr, out_valid, out_idx, out_data,
               out_last, busy, done, nz_count
    );
    modport slave (
        input  start, nz_flags, rf_read_data, out_ready,
        output rf_read_en, rf_read_addr, out_valid, out_idx, out_data,
               out_last, busy, done, nz_count
    );
`endif
endinterface

// File: rtl/nz_read_scheduler.sv
// Non-zero read scheduler: snapshots the register file's non-zero flags on
// start and streams (index, value) pairs for the set entries, lowest index
// first, one combinational register-file read per issued pair.
// Optional macro NZ_SCHED_RELU_SKIP_EN: snapshot nz_flags & pos_flags so
// negative entries are skipped (ReLU fused into the scan).
module nz_read_scheduler #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned REG_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nz_read_scheduler_if.slave    bus
);
    localparam int unsigned ADDR_W = $clog2(REG_DEPTH);
    localparam int unsigned CNT_W  = $clog2(REG_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [REG_DEPTH-1:0] r_pending;
    logic                 r_out_valid;
    logic [ADDR_W-1:0]    r_out_idx;
    logic [BIT_WIDTH-1:0] r_out_data;
    logic                 r_out_last;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_nz_count;

    logic [REG_DEPTH-1:0] w_snapshot;
    logic [ADDR_W-1:0]    w_pick;
    logic                 w_only;
    logic                 w_slot_free;
    logic                 w_issue;

    // Entries eligible for this scan
`ifdef NZ_SCHED_RELU_SKIP_EN
    assign w_snapshot = bus.nz_flags & bus.pos_flags;
`else
    assign w_snapshot = bus.nz_flags;
`endif

    // Lowest pending index, single-bit detect and issue decision
    always_comb begin
        w_pick = '0;
        for (int i = int'(REG_DEPTH) - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick = ADDR_W'(i);
            end
        end
        w_only      = (r_pending & (r_pending - REG_DEPTH'(1))) == '0;
        w_slot_free = !r_out_valid || bus.out_ready;
        w_issue     = (r_state == S_SCAN) && (r_pending != '0) && w_slot_free;
    end

    assign bus.rf_read_en   = w_issue;
    assign bus.rf_read_addr = w_issue ? w_pick : '0;

    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.nz_count  = r_nz_count;

    // Scan sequencer with registered output pair and status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nz_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pending  <= w_snapshot;
                        r_nz_count <= '0;
                        r_out_last <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_issue) begin
                        r_out_data          <= bus.rf_read_data;
                        r_out_idx           <= w_pick;
                        r_out_valid         <= 1'b1;
                        r_out_last          <= w_only;
                        r_pending[w_pick]   <= 1'b0;
                        r_nz_count          <= r_nz_count + CNT_W'(1);
                    end else begin
                        if (r_out_valid && bus.out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                        // Nothing left to issue and the slot drains this cycle
                        if ((r_pending == '0) && (!r_out_valid || bus.out_ready)) begin
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nz_read_scheduler.sv
// Bench for nz_read_scheduler: a table of directed scans, hand-written reset
// sequences and randomized scans, all checked against a queue-based model of
// the expected (index, value) stream and its timing.
module tb_nz_read_scheduler;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 64;

    logic clk;
    logic rst_n;
    logic [BW-1:0] rf [DEPTH];

    int vectors;
    int miscompares;

    nz_read_scheduler_if #(.BIT_WIDTH(BW), .REG_DEPTH(DEPTH)) bus ();

    nz_read_scheduler #(.BIT_WIDTH(BW), .REG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational register-file read port
    always_comb bus.rf_read_data = rf[bus.rf_read_addr];

    typedef struct {
        logic [63:0] flags;
        int          mode;      // 0: ready always, 1: random, 2: ready low k=2..5
        int          restart_k; // cycle of a spurious start pulse, 0 = none
        int          exp_n;
        int          exp_first;
        int          exp_last;
        int          exp_done_k;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill_rf_random();
        for (int i = 0; i < int'(DEPTH); i++) rf[i] = BW'($urandom);
    endtask

    task automatic fill_rf_sparse();
        fill_rf_random();
        rf[3]  = 16'h0011;
        rf[17] = 16'h0022;
        rf[63] = 16'hFFFF;
    endtask

    // Runs one scan; start is sampled in cycle k=0, cycles are counted from it.
    task automatic run_scan(input logic [63:0] flags, input logic [63:0] pos,
                            input int mode, input int restart_k,
                            output int n_seen, output int first_idx,
                            output int last_idx, output int done_k);
        int          exp_q[$];
        logic [63:0] snap;
        int          n, acc, issued, k, done_cnt, last_hs_k;
        logic        held_v;
        logic [63:0] held_idx, held_data;
        logic        exp_en, exp_done, exp_busy;

        snap = flags & pos;
        for (int i = 0; i < int'(DEPTH); i++) if (snap[i]) exp_q.push_back(i);
        n = exp_q.size();
        acc = 0; issued = 0; done_cnt = 0; last_hs_k = -10; held_v = 1'b0;
        held_idx = '0; held_data = '0;
        n_seen = 0; first_idx = -1; last_idx = -1; done_k = -1;

        @(negedge clk);
        bus.start = 1'b1;
        bus.nz_flags = flags;
`ifdef NZ_SCHED_RELU_SKIP_EN
        bus.pos_flags = pos;
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        k = 1;
        while (k < 600) begin
            bus.nz_flags = {$urandom, $urandom};
            bus.start = (k == restart_k);
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = !(k >= 2 && k <= 5);
            endcase
            #1;
            exp_done = (n == 0) ? (k == 2) : (acc == n && last_hs_k == k - 1);
            exp_busy = !exp_done && (done_k < 0);
            check("done", 64'(bus.done), 64'(exp_done));
            check("busy", 64'(bus.busy), 64'(exp_busy));
            exp_en = exp_busy && (issued < n) && (!bus.out_valid || bus.out_ready);
            check("rd_en", 64'(bus.rf_read_en), 64'(exp_en));
            if (exp_en) begin
                check("rd_addr", 64'(bus.rf_read_addr), 64'(exp_q[issued]));
                issued++;
            end else begin
                check("rd_addr_idle", 64'(bus.rf_read_addr), 64'd0);
            end
            if (held_v) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_idx", 64'(bus.out_idx), held_idx);
                check("hold_data", 64'(bus.out_data), held_data);
            end
            if (!exp_busy) check("valid_after_scan", 64'(bus.out_valid), 64'd0);
            held_v = 1'b0;
            if (bus.out_valid && exp_busy) begin
                if (acc >= n) begin
                    check("extra_pair", 64'(acc), 64'(n));
                end else if (bus.out_ready) begin
                    check("pair_idx", 64'(bus.out_idx), 64'(exp_q[acc]));
                    check("pair_data", 64'(bus.out_data), 64'(rf[exp_q[acc]]));
                    check("pair_last", 64'(bus.out_last), 64'(acc == n - 1));
                    if (acc == 0) first_idx = int'(bus.out_idx);
                    last_idx = int'(bus.out_idx);
                    acc++;
                    last_hs_k = k;
                end else begin
                    held_v = 1'b1;
                    held_idx = 64'(bus.out_idx);
                    held_data = 64'(bus.out_data);
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 2) break;
            @(negedge clk);
            k++;
        end
        if (k >= 600) check("scan_timeout", 64'(k), 64'd0);
        check("nz_count", 64'(bus.nz_count), 64'(n));
        check("pairs_total", 64'(acc), 64'(n));
        check("done_pulses", 64'(done_cnt), 64'd1);
        n_seen = acc;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int n_seen, first_idx, last_idx, done_k;
        logic [63:0] fl;
        vectors = 0;
        miscompares = 0;
        fill_rf_random();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.nz_flags = '0;
`ifdef NZ_SCHED_RELU_SKIP_EN
        bus.pos_flags = '1;
`endif
        bus.out_ready = 1'b1;

        tbl[0] = '{64'h0,                   0, 0, 0,  -1, -1, 2};
        tbl[1] = '{64'h8000_0000_0002_0008, 0, 0, 3,   3, 63, 5};
        tbl[2] = '{64'h8000_0000_0002_0008, 2, 0, 3,   3, 63, 9};
        tbl[3] = '{64'h8000_0000_0002_0008, 0, 2, 3,   3, 63, 5};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64,  0, 63, 66};
        tbl[5] = '{64'h8000_0000_0000_0000, 0, 0, 1,  63, 63, 3};
        tbl[6] = '{64'h0000_0000_0000_0001, 0, 0, 1,   0,  0, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_idx", 64'(bus.out_idx), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_count", 64'(bus.nz_count), 64'd0);
        check("rst_rd_en", 64'(bus.rf_read_en), 64'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            fill_rf_sparse();
            run_scan(tbl[t].flags, '1, tbl[t].mode, tbl[t].restart_k,
                     n_seen, first_idx, last_idx, done_k);
            check($sformatf("tbl%0d_n", t), 64'(n_seen), 64'(tbl[t].exp_n));
            check($sformatf("tbl%0d_first", t), 64'(first_idx), 64'(tbl[t].exp_first));
            check($sformatf("tbl%0d_last", t), 64'(last_idx), 64'(tbl[t].exp_last));
            check($sformatf("tbl%0d_done_k", t), 64'(done_k), 64'(tbl[t].exp_done_k));
        end

        // Reset after the first pair: everything clears, no done, then a clean rescan
        fill_rf_sparse();
        @(negedge clk);
        bus.start = 1'b1;
        bus.nz_flags = 64'h8000_0000_0002_0008;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check("mid_first_valid", 64'(bus.out_valid), 64'd1);
        check("mid_first_idx", 64'(bus.out_idx), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_idx", 64'(bus.out_idx), 64'd0);
        check("mid_rst_data", 64'(bus.out_data), 64'd0);
        check("mid_rst_last", 64'(bus.out_last), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_count", 64'(bus.nz_count), 64'd0);
        check("mid_rst_rd_en", 64'(bus.rf_read_en), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_no_done", 64'(bus.done), 64'd0);
        check("mid_rst_idle", 64'(bus.busy), 64'd0);
        run_scan(64'h8000_0000_0002_0008, '1, 0, 0, n_seen, first_idx, last_idx, done_k);
        check("rescan_first", 64'(first_idx), 64'd3);
        check("rescan_n", 64'(n_seen), 64'd3);

`ifdef NZ_SCHED_RELU_SKIP_EN
        fill_rf_random();
        rf[1] = 16'h8001;
        run_scan(64'h6, 64'h4, 0, 0, n_seen, first_idx, last_idx, done_k);
        check("relu_n", 64'(n_seen), 64'd1);
        check("relu_first", 64'(first_idx), 64'd2);
        check("relu_last", 64'(last_idx), 64'd2);
`endif

        // Randomized scans with random flags density and random backpressure
        for (int r = 0; r < 20; r++) begin
            fill_rf_random();
            fl = {$urandom, $urandom};
            case (r % 4)
                0: fl = fl & {$urandom, $urandom} & {$urandom, $urandom};
                1: fl = fl | {$urandom, $urandom};
                2: fl = fl & {$urandom, $urandom};
                default: ;
            endcase
`ifdef NZ_SCHED_RELU_SKIP_EN
            run_scan(fl, {$urandom, $urandom}, 1, int'($urandom_range(0, 6)),
                     n_seen, first_idx, last_idx, done_k);
`else
            run_scan(fl, '1, 1, int'($urandom_range(0, 6)),
                     n_seen, first_idx, last_idx, done_k);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
